// File: rtl/brew_sequencer.sv
// brew_sequencer: dispense-cycle sequencer sitting between the coin/credit FSM
// and the actuator drivers. Runs cup drop, grind, brew (pump) and change-coin
// ejection, and latches faults until an operator acknowledge.
//
// Optional feature: define CUP_CHECK_EN to add a CUPWAIT phase after the cup
// drop that waits for cup_ok (faulting after CUP_TIMEOUT cycles without it).
// With the macro undefined, cup_ok is ignored and CUP goes straight to GRIND.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   dispense request pulse (honoured only in IDLE)
//   rest_in    in   change-coin count, sampled with start
//   water_ok   in   water level/temperature good
//   cup_ok     in   cup present sensor (CUP_CHECK_EN builds only)
//   ack        in   fault acknowledge (honoured only in FAULT)
//   busy       out  sequencer not in IDLE
//   cup_drop   out  cup dispenser actuator
//   grinder    out  grinder motor
//   pump       out  brew pump
//   coin_eject out  change hopper, one pulse per coin
//   done       out  one-cycle pulse after a successful dispense
//   fault      out  fault latched
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// CUP      | cup_drop high for CUP_CYC cycles
// CUPWAIT  | waiting for cup_ok (CUP_CHECK_EN only), actuators off
// GRIND    | grinder high for GRIND_CYC cycles
// BREW     | pump high for BREW_CYC cycles, aborts to FAULT on !water_ok
// CHANGE   | one coin pulse every COIN_GAP cycles until the count is 0
// DONE     | done pulse, then IDLE
// FAULT    | fault high, actuators off, coin count held until ack

module brew_sequencer #(
    parameter int CUP_CYC     = 4,
    parameter int GRIND_CYC   = 8,
    parameter int BREW_CYC    = 16,
    parameter int COIN_GAP    = 3,
    parameter int REST_W      = 3,
    parameter int CUP_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [REST_W-1:0] rest_in,
    input  logic              water_ok,
    input  logic              cup_ok,
    input  logic              ack,
    output logic              busy,
    output logic              cup_drop,
    output logic              grinder,
    output logic              pump,
    output logic              coin_eject,
    output logic              done,
    output logic              fault
);

    localparam int MAX_A   = (CUP_CYC > GRIND_CYC) ? CUP_CYC : GRIND_CYC;
    localparam int MAX_B   = (MAX_A > BREW_CYC) ? MAX_A : BREW_CYC;
    localparam int MAX_C   = (MAX_B > COIN_GAP) ? MAX_B : COIN_GAP;
    localparam int MAX_ALL = (MAX_C > CUP_TIMEOUT) ? MAX_C : CUP_TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    // Down-counters load N-1 on phase entry and the phase ends when they hit 0.
    localparam logic [CW-1:0] CUP_LD   = CW'(CUP_CYC - 1);
    localparam logic [CW-1:0] GRIND_LD = CW'(GRIND_CYC - 1);
    localparam logic [CW-1:0] BREW_LD  = CW'(BREW_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(COIN_GAP - 1);
`ifdef CUP_CHECK_EN
    localparam logic [CW-1:0] WAIT_LD  = CW'(CUP_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CUP,
`ifdef CUP_CHECK_EN
        S_CUPWAIT,
`endif
        S_GRIND,
        S_BREW,
        S_CHANGE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [REST_W-1:0] coins;
    logic              faulted;

`ifndef CUP_CHECK_EN
    logic unused_cup_ok;
    assign unused_cup_ok = cup_ok;
`endif

    // Outputs are registered: each branch sets the values that belong to the
    // state being entered, on top of the all-off defaults below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            coins      <= '0;
            faulted    <= 1'b0;
            busy       <= 1'b0;
            cup_drop   <= 1'b0;
            grinder    <= 1'b0;
            pump       <= 1'b0;
            coin_eject <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            busy       <= 1'b1;
            cup_drop   <= 1'b0;
            grinder    <= 1'b0;
            pump       <= 1'b0;
            coin_eject <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        coins   <= rest_in;
                        faulted <= 1'b0;
                        busy    <= 1'b1;
                        if (!water_ok) begin
                            state   <= S_FAULT;
                            fault   <= 1'b1;
                            faulted <= 1'b1;
                        end else begin
                            state    <= S_CUP;
                            cnt      <= CUP_LD;
                            cup_drop <= 1'b1;
                        end
                    end
                end
                S_CUP: begin
                    if (cnt == '0) begin
`ifdef CUP_CHECK_EN
                        state <= S_CUPWAIT;
                        cnt   <= WAIT_LD;
`else
                        state   <= S_GRIND;
                        cnt     <= GRIND_LD;
                        grinder <= 1'b1;
`endif
                    end else begin
                        cnt      <= cnt - 1'b1;
                        cup_drop <= 1'b1;
                    end
                end
`ifdef CUP_CHECK_EN
                S_CUPWAIT: begin
                    if (cup_ok) begin
                        state   <= S_GRIND;
                        cnt     <= GRIND_LD;
                        grinder <= 1'b1;
                    end else if (cnt == '0) begin
                        state   <= S_FAULT;
                        fault   <= 1'b1;
                        faulted <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                S_GRIND: begin
                    if (cnt == '0) begin
                        state <= S_BREW;
                        cnt   <= BREW_LD;
                        pump  <= 1'b1;
                    end else begin
                        cnt     <= cnt - 1'b1;
                        grinder <= 1'b1;
                    end
                end
                S_BREW: begin
                    // Water loss wins over a normal end of brew.
                    if (!water_ok) begin
                        state   <= S_FAULT;
                        fault   <= 1'b1;
                        faulted <= 1'b1;
                    end else if (cnt == '0) begin
                        if (coins != '0) begin
                            state      <= S_CHANGE;
                            cnt        <= GAP_LD;
                            coins      <= coins - 1'b1;
                            coin_eject <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt - 1'b1;
                        pump <= 1'b1;
                    end
                end
                S_CHANGE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (coins != '0) begin
                        cnt        <= GAP_LD;
                        coins      <= coins - 1'b1;
                        coin_eject <= 1'b1;
                    end else if (faulted) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_FAULT: begin
                    // Refund whatever change was latched; an empty refund
                    // passes through CHANGE in zero cycles.
                    if (ack) begin
                        if (coins != '0) begin
                            state      <= S_CHANGE;
                            cnt        <= GAP_LD;
                            coins      <= coins - 1'b1;
                            coin_eject <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        fault <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer: randomized self-checking bench for brew_sequencer.
// Each dispense is described as a list of phases (cup, grind, brew, fault,
// coins, done) whose lengths come from the parameters; the expected per-cycle
// output trace is built from that list and compared cycle by cycle.
//
// Output vector order: {busy, cup_drop, grinder, pump, coin_eject, done, fault}

module tb_brew_sequencer;

    localparam int CUP_CYC     = 4;
    localparam int GRIND_CYC   = 8;
    localparam int BREW_CYC    = 16;
    localparam int COIN_GAP    = 3;
    localparam int REST_W      = 3;
    localparam int CUP_TIMEOUT = 32;

    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_BUSY  = 7'b1000000;
    localparam logic [6:0] V_CUP   = 7'b1100000;
    localparam logic [6:0] V_GRIND = 7'b1010000;
    localparam logic [6:0] V_PUMP  = 7'b1001000;
    localparam logic [6:0] V_COIN  = 7'b1000100;
    localparam logic [6:0] V_DONE  = 7'b1000010;
    localparam logic [6:0] V_FAULT = 7'b1000001;

    logic              clk;
    logic              reset;
    logic              start;
    logic [REST_W-1:0] rest_in;
    logic              water_ok;
    logic              cup_ok;
    logic              ack;
    logic              busy;
    logic              cup_drop;
    logic              grinder;
    logic              pump;
    logic              coin_eject;
    logic              done;
    logic              fault;
    logic [6:0]        obs;

    int n_checks = 0;
    int n_errors = 0;

    assign obs = {busy, cup_drop, grinder, pump, coin_eject, done, fault};

    brew_sequencer #(
        .CUP_CYC    (CUP_CYC),
        .GRIND_CYC  (GRIND_CYC),
        .BREW_CYC   (BREW_CYC),
        .COIN_GAP   (COIN_GAP),
        .REST_W     (REST_W),
        .CUP_TIMEOUT(CUP_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rest_in   (rest_in),
        .water_ok  (water_ok),
        .cup_ok    (cup_ok),
        .ack       (ack),
        .busy      (busy),
        .cup_drop  (cup_drop),
        .grinder   (grinder),
        .pump      (pump),
        .coin_eject(coin_eject),
        .done      (done),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // mode 0: clean dispense; 1: water bad at start; 2: water lost after
    // brew_len pump cycles. fault_len is the number of FAULT cycles before ack.
    task automatic run_txn(input int rest, input int mode, input int brew_len,
                           input int fault_len, input string tag);
        logic [6:0] exp_q[$];
        int faulted  = 0;
        int drop     = -1;
        int f_lo     = -1;
        int ack_edge = -1;
        int n;

        if (mode == 1) begin
            drop    = 0;
            faulted = 1;
        end else begin
            repeat (CUP_CYC) exp_q.push_back(V_CUP);
`ifdef CUP_CHECK_EN
            exp_q.push_back(V_BUSY);
`endif
            repeat (GRIND_CYC) exp_q.push_back(V_GRIND);
            if (mode == 2) begin
                repeat (brew_len) exp_q.push_back(V_PUMP);
                drop    = exp_q.size();
                faulted = 1;
            end else begin
                repeat (BREW_CYC) exp_q.push_back(V_PUMP);
            end
        end
        if (faulted != 0) begin
            f_lo = exp_q.size() + 1;
            repeat (fault_len) exp_q.push_back(V_FAULT);
            ack_edge = exp_q.size();
        end
        for (int c = 0; c < rest; c++) begin
            exp_q.push_back(V_COIN);
            repeat (COIN_GAP - 1) exp_q.push_back(V_BUSY);
        end
        if (faulted == 0) exp_q.push_back(V_DONE);
        n = exp_q.size();

        @(negedge clk);
        start    = 1'b1;
        rest_in  = REST_W'(rest);
        water_ok = (drop == 0) ? 1'b0 : 1'b1;
        ack      = ($urandom_range(0, 3) == 0);
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            check_val(tag, obs, (i <= n) ? exp_q[i-1] : V_IDLE);
            start    = (i <= n) && ($urandom_range(0, 5) == 0);
            rest_in  = REST_W'($urandom);
            water_ok = !(drop >= 0 && i >= drop && i <= ack_edge);
            if (i == ack_edge)
                ack = 1'b1;
            else if (f_lo >= 0 && i >= f_lo && i < ack_edge)
                ack = 1'b0;
            else
                ack = ($urandom_range(0, 7) == 0);
        end
        start    = 1'b0;
        ack      = 1'b0;
        water_ok = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rest_in  = '0;
        water_ok = 1'b1;
        cup_ok   = 1'b1;
        ack      = 1'b0;

        #12;
        check_val("reset_state", obs, V_IDLE);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_after_reset", obs, V_IDLE);

        run_txn(0, 0, 0, 0, "nominal_rest0");
        run_txn(2, 0, 0, 0, "nominal_rest2");
        run_txn(3, 2, 8, 4, "water_lost_rest3");
        run_txn(2, 1, 0, 3, "water_bad_start");
        run_txn(0, 1, 0, 2, "water_bad_rest0");
        run_txn(7, 2, BREW_CYC, 1, "water_lost_last_brew");
        run_txn(7, 0, 0, 0, "nominal_rest_max");

        // Asynchronous reset in the middle of GRIND, away from any clock edge.
        @(negedge clk);
        start    = 1'b1;
        rest_in  = 3'd5;
        water_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (CUP_CYC + 2) @(negedge clk);
        check_val("grind_before_reset", obs, V_GRIND);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset_abort", obs, V_IDLE);
        @(negedge clk);
        check_val("held_in_reset", obs, V_IDLE);
        reset = 1'b1;
        @(negedge clk);
        check_val("idle_after_abort", obs, V_IDLE);
        run_txn(0, 0, 0, 0, "nominal_after_reset");

        for (int t = 0; t < 40; t++) begin
            int m;
            m = int'($urandom_range(0, 2));
            run_txn(int'($urandom_range(0, 7)), m, int'($urandom_range(1, BREW_CYC)),
                    int'($urandom_range(1, 6)), "random");
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_val("idle_gap", obs, V_IDLE);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Sequences the physical dispense cycle once the coin-acceptor FSM grants a coffee: cup drop, grind, brew (pump), then change-coin ejection.
- Sits between the coin/credit FSM (its `cafea`/`rest` outputs drive `start`/`rest_in`) and the actuator drivers.
- Owns all actuator timing and fault handling; the credit FSM only decides *when* and *how much change*.

Parameters:
- CUP_CYC, 4: cycles `cup_drop` is held high.
- GRIND_CYC, 8: cycles `grinder` is held high.
- BREW_CYC, 16: cycles `pump` is held high.
- COIN_GAP, 3: cycles per ejected coin (1 pulse + COIN_GAP-1 gap); minimum 2.
- REST_W, 3: width of the change-coin count.
- CUP_TIMEOUT, 32: max wait cycles for `cup_ok` (CUP_CHECK_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  dispense request (1-cycle pulse from credit FSM).
- rest_in  in  REST_W  number of change coins, sampled with `start`.
- water_ok  in  1  water level/temperature good.
- cup_ok  in  1  cup present sensor (used only with CUP_CHECK_EN).
- ack  in  1  operator/service fault acknowledge.
- busy  out  1  sequencer not in IDLE.
- cup_drop  out  1  cup dispenser actuator.
- grinder  out  1  grinder motor.
- pump  out  1  brew pump.
- coin_eject  out  1  change hopper, one pulse per coin.
- done  out  1  1-cycle pulse: successful dispense complete.
- fault  out  1  fault latched.

Behaviour:
- All outputs are registered (Moore). Reset (`reset`=0, async) forces state IDLE, counters 0, coin register 0, and every output 0.
- States: IDLE, CUP, [CUPWAIT], GRIND, BREW, CHANGE, DONE, FAULT.
- IDLE:
  - On `start`=1 at edge N: latch `rest_in` and clear the `faulted` flag.
  - If `water_ok`=0 at that edge, go to FAULT; else go to CUP.
  - `busy`=1 from cycle N+1.
- `start` is ignored in every state other than IDLE. No queuing.
- CUP: `cup_drop`=1 for exactly CUP_CYC cycles, then GRIND.
- GRIND: `grinder`=1 for exactly GRIND_CYC cycles, then BREW.
- BREW:
  - `pump`=1 for exactly BREW_CYC cycles, then CHANGE.
  - `water_ok` is sampled every BREW cycle. If it is 0, go to FAULT next edge; `pump` drops that same cycle.
- CHANGE:
  - If the coin count is 0, go directly to DONE (0 cycles spent in CHANGE).
  - Otherwise each coin takes COIN_GAP cycles: `coin_eject`=1 in the first cycle, 0 for the rest; the count decrements on the pulse.
  - After the last coin's gap: go to DONE if `faulted`=0, else IDLE.
- DONE: `done`=1 for one cycle, then IDLE (`busy`=0 the cycle after).
- FAULT:
  - `fault`=1 and `faulted`=1; all actuators 0; the coin count is preserved.
  - Stays in FAULT until `ack`=1, then goes to CHANGE to refund the latched change. `done` is never pulsed after a fault.
  - `fault` clears when leaving FAULT.
- Only one actuator output is high in any cycle.
- Phase counters are sized $clog2 of the largest parameter + 1. No wrap-around is possible; each counter reloads on phase entry.
- `rest_in` = 2^REST_W−1 is legal (max coins).
- `ack` outside FAULT is ignored.
- Async reset mid-operation aborts immediately with no refund; the coin count is lost.

Optional Feature:
- Macro: CUP_CHECK_EN.
- Defined:
  - After CUP, enter CUPWAIT; all actuators are 0.
  - Proceed to GRIND on the first cycle `cup_ok`=1.
  - If `cup_ok` stays 0 for CUP_TIMEOUT cycles, go to FAULT.
  - If `cup_ok`=1 already on the first CUPWAIT cycle, CUPWAIT lasts 1 cycle.
- Undefined: CUPWAIT does not exist; CUP goes straight to GRIND; `cup_ok` is ignored.

Test Plan:
- Default parameters, `water_ok`=1, `start` with `rest_in`=0 at edge 0 → `cup_drop` high cycles 1–4, `grinder` 5–12, `pump` 13–28, `done` at cycle 29, `busy` low at 30, `coin_eject` never high.
- Same, `rest_in`=2 → `coin_eject` pulses at cycles 29 and 32 only, `done` at 35.
- `water_ok` falls at brew cycle 20, `rest_in`=3 → `pump` 0 from cycle 20, `fault`=1 held. `ack` pulse → 3 `coin_eject` pulses 3 cycles apart, return to IDLE, no `done`.
- `start` with `water_ok`=0 → FAULT at cycle 1, no actuator ever high. Extra `start` pulses during BREW and FAULT → ignored, timing unchanged.
- `reset` asserted (low) mid-GRIND, async between edges → all outputs 0 immediately, IDLE. A new `start` afterwards runs a full nominal sequence.
- With CUP_CHECK_EN, `cup_ok`=0 held → FAULT exactly 32 cycles after CUPWAIT entry. With `cup_ok` rising at wait cycle 5 → GRIND starts the next cycle.
